ex_mem_skid: RTL and testbench
==============================

# ex_mem_skid

Registered EX→MEM boundary directly downstream of the ALU. Captures the ALU result and Zero flag with the instruction's memory/writeback controls and resolves branches. Raises a one-cycle PC redirect for a taken branch or jump. A 2-entry skid buffer decouples the execute stage from a stalling memory stage without losing throughput.

## Interface
Parameters:
- XLEN, 32, datapath width of result, store data and target.

Ports (reset is synchronous, active-high, on `clk`):
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous active-high reset.
- flush  in  1  synchronous kill of all buffered entries and any pending redirect.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  block can accept this cycle.
- in_alu_out  in  XLEN  ALU result.
- in_zero  in  1  ALU Zero flag. Already polarity-adjusted by the ALU, so 1 means the branch condition is met.
- in_branch  in  1  conditional branch.
- in_jump  in  1  unconditional jump (jal/jalr).
- in_target  in  XLEN  branch/jump target address.
- in_store_data  in  XLEN  rs2 value for stores.
- in_rd  in  5  destination register.
- in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits.
- out_valid  out  1  head entry valid toward MEM.
- out_ready  in  1  MEM consumes head this cycle.
- out_alu_out, out_store_data  out  XLEN  head entry fields.
- out_rd  out  5; out_reg_write, out_mem_read, out_mem_write  out  1 each  head entry fields.
- redirect  out  1  one-cycle pulse: PC must load redirect_pc.
- redirect_pc  out  XLEN  target associated with the redirect.
- fwd_valid  out  1; fwd_rd  out  5; fwd_data  out  XLEN  forwarding port (see Configuration).

## Operation
- Storage: head register H (drives out_*) and skid register S, each with a valid bit. Occupancy is 0, 1 or 2.
- Accept: `acc = in_valid & in_ready`. Pop: `pop = out_valid & out_ready`.
- `in_ready = !S.valid`. This is a registered-state function only, with no combinational path from out_ready.
- Pop and accept in the same cycle:
  - S valid: S moves to H, and the incoming instruction goes to S. This cannot occur, because in_ready=0 when S is valid.
  - S empty: the incoming instruction goes to H.
- Accept with H valid and no pop: the incoming instruction goes to S.
- Pop with no accept: S moves to H (S cleared); otherwise H is cleared.
- Branch resolution happens on accept: `taken = in_jump | (in_branch & in_zero)`. If taken, the next cycle has redirect=1 and redirect_pc=in_target, otherwise redirect=0.
- A redirecting instruction is still enqueued normally (jal writes rd).
- All stored fields are copied unmodified; no arithmetic or width conversion.
- Priority: reset > flush > normal operation.
  - flush clears H.valid, S.valid and the redirect that would be raised next cycle.
  - A same-cycle accept is discarded.
  - redirect already high in the flush cycle stays high; it is a registered output.
- out_* data fields hold their last value when out_valid=0. Only the valid bits are reset.

## Timing
- Reset values: out_valid=0, in_ready=1 (the cycle after reset), redirect=0, redirect_pc=0, fwd_valid=0, fwd_rd=0, fwd_data=0. All out_* data fields are 0.
- Latency: accept in cycle N → out_valid=1 and redirect (if taken) in cycle N+1.
- Throughput: 1 instruction/cycle while out_ready=1.
- Backpressure:
  - out_ready low for one cycle with a continuous stream: S fills and in_ready drops the next cycle.
  - in_ready returns one cycle after the pop that empties S.
- Handshake rules:
  - out_* stay stable while out_valid=1 and out_ready=0.
  - The upstream stage must hold in_* stable while in_valid=1 and in_ready=0.
- redirect is never high for two consecutive cycles from one instruction.
- Back-to-back taken instructions produce back-to-back pulses, each with its own target.

## Configuration
- EX_MEM_FWD_EN defined:
  - fwd_valid = H.valid & out_reg_write & !out_mem_read & (out_rd≠0).
  - fwd_rd = out_rd; fwd_data = out_alu_out. Combinational from H.
- Not defined: fwd_valid, fwd_rd and fwd_data are tied to 0. The ports always exist.

## Test plan
- Reset mid-stream (H and S valid, redirect pending) → next cycle out_valid=0, in_ready=1, redirect=0.
- Stream add results 1,2,3,4 with out_ready=1 → out_alu_out 1,2,3,4 on consecutive cycles one cycle after each accept; in_ready stays 1.
- Stream 10,11,12 with out_ready=0 for 3 cycles → in_ready drops after 2 accepts, out_alu_out holds 10. Releasing out_ready yields 10,11,12 in order with no loss or duplicate.
- Branch accept with in_branch=1, in_zero=1, in_target=0x100 → redirect=1, redirect_pc=0x100 for exactly one cycle. Same with in_zero=0 → redirect stays 0.
- flush asserted in the same cycle as a jump accept (target 0x200) with 2 entries buffered → next cycle out_valid=0, redirect=0, in_ready=1.
- With EX_MEM_FWD_EN: head entry rd=5, reg_write=1, alu_out=0x2A → fwd_valid=1, fwd_rd=5, fwd_data=0x2A. With rd=0 or mem_read=1 → fwd_valid=0.

Source files
------------

// File: rtl/ex_mem_skid.sv
// rtl/ex_mem_skid.sv - EX/MEM pipeline register with 2-entry skid buffer and branch redirect
//
// Purpose: registers the ALU result, store data and MEM/WB controls of each
// accepted instruction. Taken branches and jumps produce a one-cycle PC
// redirect. A head/skid register pair absorbs one cycle of MEM backpressure
// without a combinational ready path.
//
// Optional feature macro: EX_MEM_FWD_EN (head-entry forwarding port).
//
// Ports:
//   clk, reset (sync, active-high), flush (kills buffered entries and pending redirect)
//   in_valid / in_ready          execute-side handshake
//   in_alu_out, in_zero, in_branch, in_jump, in_target, in_store_data,
//   in_rd, in_reg_write, in_mem_read, in_mem_write   execute-side fields
//   out_valid / out_ready        memory-side handshake
//   out_alu_out, out_store_data, out_rd, out_reg_write, out_mem_read,
//   out_mem_write                head entry fields
//   redirect, redirect_pc        one-cycle PC redirect
//   fwd_valid, fwd_rd, fwd_data  forwarding from head entry (0 when disabled)

module ex_mem_skid #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_alu_out,
   input  logic            in_zero,
   input  logic            in_branch,
   input  logic            in_jump,
   input  logic [XLEN-1:0] in_target,
   input  logic [XLEN-1:0] in_store_data,
   input  logic [4:0]      in_rd,
   input  logic            in_reg_write,
   input  logic            in_mem_read,
   input  logic            in_mem_write,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_alu_out,
   output logic [XLEN-1:0] out_store_data,
   output logic [4:0]      out_rd,
   output logic            out_reg_write,
   output logic            out_mem_read,
   output logic            out_mem_write,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            fwd_valid,
   output logic [4:0]      fwd_rd,
   output logic [XLEN-1:0] fwd_data
);

   // Entry layout: {alu_out, store_data, rd, reg_write, mem_read, mem_write}
   localparam int EW = 2*XLEN + 8;

   logic [EW-1:0] h_q;
   logic [EW-1:0] s_q;
   logic          h_valid;
   logic          s_valid;
   logic [EW-1:0] in_entry;
   logic          acc;
   logic          pop;
   logic          taken;

   assign in_entry = {in_alu_out, in_store_data, in_rd, in_reg_write, in_mem_read, in_mem_write};

   // Ready depends only on registered state, so MEM stalls never reach EX combinationally.
   assign in_ready  = !s_valid;
   assign out_valid = h_valid;
   assign acc       = in_valid & in_ready;
   assign pop       = h_valid & out_ready;
   assign taken     = in_jump | (in_branch & in_zero);

   assign {out_alu_out, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write} = h_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         h_valid     <= 1'b0;
         s_valid     <= 1'b0;
         h_q         <= '0;
         s_q         <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
      end else if (flush) begin
         // Data fields are left as-is; only validity and the pending redirect die.
         h_valid  <= 1'b0;
         s_valid  <= 1'b0;
         redirect <= 1'b0;
      end else begin
         redirect <= acc & taken;
         if (acc & taken) begin
            redirect_pc <= in_target;
         end

         // acc implies S is empty, so S->H and input->S never coincide.
         if (acc && (!h_valid || pop)) begin
            h_q     <= in_entry;
            h_valid <= 1'b1;
         end else if (acc) begin
            s_q     <= in_entry;
            s_valid <= 1'b1;
         end else if (pop) begin
            if (s_valid) begin
               h_q     <= s_q;
               s_valid <= 1'b0;
            end else begin
               h_valid <= 1'b0;
            end
         end
      end
   end

`ifdef EX_MEM_FWD_EN
   // Loads are excluded: their alu_out is an address, not the rd value.
   assign fwd_valid = h_valid & out_reg_write & !out_mem_read & (out_rd != 5'd0);
   assign fwd_rd    = out_rd;
   assign fwd_data  = out_alu_out;
`else
   assign fwd_valid = 1'b0;
   assign fwd_rd    = 5'd0;
   assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid.sv
// tb/tb_ex_mem_skid.sv - self-checking bench for ex_mem_skid

module tb_ex_mem_skid;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_alu_out;
   logic        in_zero;
   logic        in_branch;
   logic        in_jump;
   logic [31:0] in_target;
   logic [31:0] in_store_data;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic        in_mem_read;
   logic        in_mem_write;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_alu_out;
   logic [31:0] out_store_data;
   logic [4:0]  out_rd;
   logic        out_reg_write;
   logic        out_mem_read;
   logic        out_mem_write;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;

   logic [71:0] sb_q[$];

   ex_mem_skid #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_out(in_alu_out), .in_zero(in_zero), .in_branch(in_branch),
      .in_jump(in_jump), .in_target(in_target), .in_store_data(in_store_data),
      .in_rd(in_rd), .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
      .in_mem_write(in_mem_write),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_out(out_alu_out), .out_store_data(out_store_data), .out_rd(out_rd),
      .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
      .out_mem_write(out_mem_write),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [31:0] alu, input logic br, input logic jp,
                        input logic z, input logic [31:0] tgt, input logic [4:0] rd,
                        input logic rw, input logic mr);
      in_valid      = v;
      in_alu_out    = alu;
      in_branch     = br;
      in_jump       = jp;
      in_zero       = z;
      in_target     = tgt;
      in_store_data = alu ^ 32'hA5A5_0000;
      in_rd         = rd;
      in_reg_write  = rw;
      in_mem_read   = mr;
      in_mem_write  = !rw & !mr & !br & !jp;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
   endtask

   // One clock: scoreboard pushes accepted entries and compares popped heads
   // at the negedge, then the edge is taken and outputs settle.
   task automatic tick();
      logic [71:0] exp_e;
      logic [71:0] got_e;
      logic        acc;
      logic        pop;
      @(negedge clk);
      acc = in_valid & in_ready;
      pop = out_valid & out_ready;
      if (reset) begin
         sb_q.delete();
      end else begin
         if (pop) begin
            n_checks++;
            n_pops++;
            if (sb_q.size() == 0) begin
               n_fail++;
               $display("FAIL sb_pop: head popped with nothing expected, got alu=%h", out_alu_out);
            end else begin
               exp_e = sb_q.pop_front();
               got_e = {out_alu_out, out_store_data, out_rd, out_reg_write, out_mem_read, out_mem_write};
               if (got_e !== exp_e) begin
                  n_fail++;
                  $display("FAIL sb_pop: got %h expected %h", got_e, exp_e);
               end
            end
         end
         if (flush) sb_q.delete();
         else if (acc) sb_q.push_back({in_alu_out, in_store_data, in_rd, in_reg_write, in_mem_read, in_mem_write});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      idle();
      out_ready = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
      idle();
      repeat (2) tick();
      reset = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, redirect} !== 3'b010) begin
         n_fail++;
         $display("FAIL reset_ctrl: got v/r/redir=%b expected 010", {out_valid, in_ready, redirect});
      end
      n_checks++;
      if ({redirect_pc, out_alu_out, out_store_data, out_rd} !== 101'd0) begin
         n_fail++;
         $display("FAIL reset_data: pc=%h alu=%h sd=%h rd=%0d expected all 0", redirect_pc, out_alu_out, out_store_data, out_rd);
      end
      n_checks++;
      if ({fwd_valid, fwd_rd, fwd_data} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_fwd: got %b/%0d/%h expected 0", fwd_valid, fwd_rd, fwd_data);
      end
   endtask

   task automatic test_stream();
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         drive(1'b1, k, 1'b0, 1'b0, 1'b0, 32'h0, 5'd3, 1'b1, 1'b0);
         n_checks++;
         if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_ready: k=%0d got %b expected 1", k, in_ready);
         end
         tick();
         n_checks++;
         if (out_valid !== 1'b1 || out_alu_out !== k) begin
            n_fail++;
            $display("FAIL stream_out: got v=%b alu=%0d expected v=1 alu=%0d", out_valid, out_alu_out, k);
         end
      end
      idle();
      tick();
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stream_empty: got out_valid=%b expected 0", out_valid);
      end
   endtask

   task automatic test_backpressure();
      int pops0;
      pops0 = n_pops;
      out_ready = 1'b0;
      drive(1'b1, 32'd10, 1'b0, 1'b0, 1'b0, 32'h0, 5'd4, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'd11, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_alu_out !== 32'd10) begin
         n_fail++;
         $display("FAIL bp_full: got ready=%b alu=%0d expected 0/10", in_ready, out_alu_out);
      end
      drive(1'b1, 32'd12, 1'b0, 1'b0, 1'b0, 32'h0, 5'd6, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (in_ready !== 1'b0 || out_alu_out !== 32'd10 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_hold: got ready=%b v=%b alu=%0d expected 0/1/10", in_ready, out_valid, out_alu_out);
      end
      out_ready = 1'b1;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || out_alu_out !== 32'd11) begin
         n_fail++;
         $display("FAIL bp_release: got ready=%b alu=%0d expected 1/11", in_ready, out_alu_out);
      end
      tick();
      idle();
      tick();
      n_checks++;
      if (n_pops - pops0 !== 3 || sb_q.size() !== 0 || out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_count: got pops=%0d left=%0d v=%b expected 3/0/0", n_pops - pops0, sb_q.size(), out_valid);
      end
   endtask

   task automatic test_branch();
      out_ready = 1'b1;
      drive(1'b1, 32'h50, 1'b1, 1'b0, 1'b1, 32'h100, 5'd0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (redirect !== 1'b1 || redirect_pc !== 32'h100) begin
         n_fail++;
         $display("FAIL br_taken: got redir=%b pc=%h expected 1/100", redirect, redirect_pc);
      end
      idle();
      tick();
      n_checks++;
      if (redirect !== 1'b0) begin
         n_fail++;
         $display("FAIL br_pulse: got redir=%b expected 0", redirect);
      end
      drive(1'b1, 32'h51, 1'b1, 1'b0, 1'b0, 32'h180, 5'd0, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (redirect !== 1'b0 || out_alu_out !== 32'h51) begin
         n_fail++;
         $display("FAIL br_not_taken: got redir=%b alu=%h expected 0/51", redirect, out_alu_out);
      end
      drive(1'b1, 32'h60, 1'b0, 1'b1, 1'b0, 32'h300, 5'd1, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (redirect !== 1'b1 || redirect_pc !== 32'h300) begin
         n_fail++;
         $display("FAIL jmp_first: got redir=%b pc=%h expected 1/300", redirect, redirect_pc);
      end
      drive(1'b1, 32'h61, 1'b0, 1'b1, 1'b0, 32'h304, 5'd1, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (redirect !== 1'b1 || redirect_pc !== 32'h304) begin
         n_fail++;
         $display("FAIL jmp_second: got redir=%b pc=%h expected 1/304", redirect, redirect_pc);
      end
      idle();
      tick();
      n_checks++;
      if (redirect !== 1'b0) begin
         n_fail++;
         $display("FAIL jmp_end: got redir=%b expected 0", redirect);
      end
      drain();
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      drive(1'b1, 32'd20, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'd21, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'd22, 1'b0, 1'b1, 1'b0, 32'h200, 5'd1, 1'b1, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_checks++;
      if ({out_valid, redirect, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL flush_full: got v/redir/ready=%b expected 001", {out_valid, redirect, in_ready});
      end
      drive(1'b1, 32'd23, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'd24, 1'b0, 1'b1, 1'b0, 32'h204, 5'd1, 1'b1, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      idle();
      n_checks++;
      if ({out_valid, redirect, in_ready} !== 3'b001) begin
         n_fail++;
         $display("FAIL flush_accept: got v/redir/ready=%b expected 001", {out_valid, redirect, in_ready});
      end
      drain();
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      drive(1'b1, 32'd30, 1'b0, 1'b0, 1'b0, 32'h0, 5'd2, 1'b1, 1'b0);
      tick();
      drive(1'b1, 32'd31, 1'b0, 1'b1, 1'b0, 32'h400, 5'd1, 1'b1, 1'b0);
      tick();
      idle();
      n_checks++;
      if ({out_valid, in_ready, redirect} !== 3'b101 || redirect_pc !== 32'h400) begin
         n_fail++;
         $display("FAIL rst_mid_pre: got v/ready/redir=%b pc=%h expected 101/400", {out_valid, in_ready, redirect}, redirect_pc);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_checks++;
      if ({out_valid, in_ready, redirect} !== 3'b010) begin
         n_fail++;
         $display("FAIL rst_mid: got v/ready/redir=%b expected 010", {out_valid, in_ready, redirect});
      end
   endtask

   task automatic test_fwd();
      logic [37:0] exp_f;
      out_ready = 1'b0;
      drive(1'b1, 32'h2A, 1'b0, 1'b0, 1'b0, 32'h0, 5'd5, 1'b1, 1'b0);
      tick();
`ifdef EX_MEM_FWD_EN
      exp_f = {1'b1, 5'd5, 32'h2A};
`else
      exp_f = 38'd0;
`endif
      n_checks++;
      if ({fwd_valid, fwd_rd, fwd_data} !== exp_f) begin
         n_fail++;
         $display("FAIL fwd_hit: got %b/%0d/%h expected %h", fwd_valid, fwd_rd, fwd_data, exp_f);
      end
      out_ready = 1'b1;
      drive(1'b1, 32'h2B, 1'b0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (fwd_valid !== 1'b0 || out_alu_out !== 32'h2B) begin
         n_fail++;
         $display("FAIL fwd_rd0: got fv=%b alu=%h expected 0/2B", fwd_valid, out_alu_out);
      end
      drive(1'b1, 32'h2C, 1'b0, 1'b0, 1'b0, 32'h0, 5'd7, 1'b1, 1'b1);
      tick();
      n_checks++;
      if (fwd_valid !== 1'b0 || out_alu_out !== 32'h2C) begin
         n_fail++;
         $display("FAIL fwd_load: got fv=%b alu=%h expected 0/2C", fwd_valid, out_alu_out);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_branch();
      test_flush();
      test_reset_mid();
      test_fwd();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
